// File: rtl/prio_enc_queue.sv
// prio_enc_queue
//   Priority encoder with a pending-request register and a one-entry
//   registered output slot (valid/ready handshake).
//
//   Requests on din (active-low) are captured into the pending set P while
//   sel is low. Each cycle the output slot is free, one pending index is
//   picked and presented on dout as the code N-1-index.
//
//   Build option (macro PRIO_ROUND_ROBIN_EN):
//     undefined : fixed priority, the highest pending index wins.
//     defined   : round robin. The search runs downward from pointer R and
//                 wraps from 0 to N-1. After index i is loaded, R becomes
//                 (i-1) mod N.
//
// Ports
//   clk   in   sole clock, rising edge
//   rst   in   synchronous active-high reset
//   sel   in   capture enable, active-low
//   din   in   [N-1:0] request lines, active-low (din[i]=0 requests i)
//   dout  out  [W-1:0] registered code of the presented request
//   vld   out  dout holds a valid code
//   rdy   in   consumer accepts dout when vld && rdy at a rising edge
//   Ys    out  idle flag, active-low (enabled, nothing pending, slot empty)
//   Yex   out  expansion flag, active-low, low whenever vld is high
module prio_enc_queue #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [N-1:0] din,
  output logic [W-1:0] dout,
  output logic         vld,
  input  logic         rdy,
  output logic         Ys,
  output logic         Yex
);

  logic [N-1:0] pend;
  logic [N-1:0] pend_nxt;
  logic [N-1:0] cap;
  logic [W-1:0] dout_nxt;
  logic [W-1:0] win;
  logic         vld_nxt;
  logic         slot_free;
  logic         ys_nxt;

`ifdef PRIO_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;

  // The loop runs from the farthest distance to the nearest, so the last hit
  // is the set bit closest to r in the downward direction.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] p,
                                           input logic [W-1:0] r);
    logic [W-1:0] w;
    int           idx;
    w = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(r) - k + N) % N;
      if (p[idx[W-1:0]]) w = idx[W-1:0];
    end
    return w;
  endfunction
`else
  // The last hit in an ascending scan is the highest set index.
  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] p);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i[W-1:0]]) w = i[W-1:0];
    end
    return w;
  endfunction
`endif

  always_comb begin
    cap       = sel ? '0 : ~din;
    slot_free = !vld || rdy;
`ifdef PRIO_ROUND_ROBIN_EN
    win       = pick_rr(pend, ptr);
    ptr_nxt   = ptr;
`else
    win       = pick_fixed(pend);
`endif
    pend_nxt  = pend;
    vld_nxt   = vld;
    dout_nxt  = dout;

    // The winner comes from the registered P only; this cycle's captures are
    // merged in afterwards, so a re-capture of the loaded index survives.
    if (slot_free) begin
      if (|pend) begin
        pend_nxt[win] = 1'b0;
        vld_nxt       = 1'b1;
        dout_nxt      = W'(N - 1) - win;
`ifdef PRIO_ROUND_ROBIN_EN
        ptr_nxt       = (win == '0) ? W'(N - 1) : win - 1'b1;
`endif
      end else begin
        vld_nxt = 1'b0;
      end
    end
    pend_nxt = pend_nxt | cap;

    ys_nxt = sel || (|pend_nxt) || vld_nxt;
  end

  // Stage boundary: pending set, output slot and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      vld  <= 1'b0;
      dout <= '1;
      Ys   <= 1'b1;
      Yex  <= 1'b1;
`ifdef PRIO_ROUND_ROBIN_EN
      ptr  <= W'(N - 1);
`endif
    end else begin
      pend <= pend_nxt;
      vld  <= vld_nxt;
      dout <= dout_nxt;
      Ys   <= ys_nxt;
      Yex  <= !vld_nxt;
`ifdef PRIO_ROUND_ROBIN_EN
      ptr  <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_prio_enc_queue.sv
// tb_prio_enc_queue
//   Directed scenarios followed by randomized traffic, with every cycle
//   compared against a behavioural model of the pending set and output slot.
//   Honours PRIO_ROUND_ROBIN_EN for the arbitration policy.
module tb_prio_enc_queue;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic [N-1:0] din = '1;
  logic         rdy = 1'b1;
  logic [W-1:0] dout;
  logic         vld;
  logic         Ys;
  logic         Yex;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_p [N];
  int m_dout = 7;
  bit m_vld  = 1'b0;
  bit m_ys   = 1'b1;
  bit m_yex  = 1'b1;
`ifdef PRIO_ROUND_ROBIN_EN
  int m_r    = N - 1;
`endif

  prio_enc_queue #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .sel  (sel),
    .din  (din),
    .dout (dout),
    .vld  (vld),
    .rdy  (rdy),
    .Ys   (Ys),
    .Yex  (Yex)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the current inputs to the model as one rising edge.
  task automatic model_edge();
    bit cap [N];
    bit any;
    int win;
    if (rst) begin
      for (int i = 0; i < N; i++) m_p[i] = 1'b0;
      m_vld  = 1'b0;
      m_dout = N - 1;
      m_ys   = 1'b1;
      m_yex  = 1'b1;
`ifdef PRIO_ROUND_ROBIN_EN
      m_r    = N - 1;
`endif
    end else begin
      for (int i = 0; i < N; i++) cap[i] = !sel && !din[i];
      win = -1;
`ifdef PRIO_ROUND_ROBIN_EN
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_r - k + N) % N;
        if (m_p[idx] && win < 0) win = idx;
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
        if (m_p[i] && win < 0) win = i;
      end
`endif
      if (!m_vld || rdy) begin
        if (win >= 0) begin
          m_dout   = N - 1 - win;
          m_vld    = 1'b1;
          m_p[win] = 1'b0;
`ifdef PRIO_ROUND_ROBIN_EN
          m_r      = (win + N - 1) % N;
`endif
        end else begin
          m_vld = 1'b0;
        end
      end
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_p[i] = m_p[i] | cap[i];
        any    = any | m_p[i];
      end
      m_ys  = sel || any || m_vld;
      m_yex = !m_vld;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_dout", dout, m_dout);
    chk("m_vld",  vld,  m_vld);
    chk("m_Ys",   Ys,   m_ys);
    chk("m_Yex",  Yex,  m_yex);
  endtask

  int e34 [3];
  int e36;
  int e37 [4];

  initial begin
`ifdef PRIO_ROUND_ROBIN_EN
    e34 = '{2, 7, 0};
    e36 = 2;
    e37 = '{0, 7, 0, 7};
`else
    e34 = '{0, 2, 7};
    e36 = 0;
    e37 = '{0, 0, 0, 0};
`endif

    // Reset state
    rst = 1'b1; sel = 1'b0; din = '1; rdy = 1'b1;
    step();
    step();
    chk("rst_dout", dout, 3'b111);
    chk("rst_vld",  vld,  1'b0);
    chk("rst_Ys",   Ys,   1'b1);
    chk("rst_Yex",  Yex,  1'b1);

    // Single request on index 7, two-edge latency
    rst = 1'b0; din = 8'b0111_1111;
    step();
    din = '1;
    step();
    chk("lat_dout", dout, 3'b000);
    chk("lat_vld",  vld,  1'b1);
    chk("lat_Yex",  Yex,  1'b0);
    chk("lat_Ys",   Ys,   1'b1);
    step();
    chk("lat_vld_off", vld, 1'b0);
    chk("lat_Ys_idle", Ys,  1'b0);

    // Three simultaneous requests drain one per cycle
    din = 8'b0101_1110;
    step();
    din = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("multi_dout", dout, e34[k]);
      chk("multi_vld",  vld,  1'b1);
    end
    step();
    chk("multi_vld_off", vld, 1'b0);

    // Back-pressure holds the slot while a new request waits
    rdy = 1'b0; din = 8'b1110_1111;
    step();
    din = '1;
    step();
    chk("bp_load", dout, 3'b011);
    din = 8'b1011_1111;
    step();
    chk("bp_hold_dout", dout, 3'b011);
    chk("bp_hold_vld",  vld,  1'b1);
    din = '1;
    step();
    chk("bp_hold2_dout", dout, 3'b011);
    rdy = 1'b1;
    step();
    chk("bp_next_dout", dout, 3'b001);
    chk("bp_next_vld",  vld,  1'b1);
    step();
    chk("bp_vld_off", vld, 1'b0);

    // sel high blocks capture
    sel = 1'b1; din = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("blk_vld", vld, 1'b0);
      chk("blk_Ys",  Ys,  1'b1);
    end
    sel = 1'b0;
    step();
    chk("blk_cap_vld", vld, 1'b0);
    din = '1;
    step();
    chk("blk_first", dout, e36);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("blk_drain_vld", vld, 1'b1);
    end
    step();
    chk("blk_empty", vld, 1'b0);

    // Reset discards a held output and the pending set
    rdy = 1'b0; din = 8'h0F;
    step();
    din = '1;
    step();
    chk("rst_mid_vld", vld, 1'b1);
    din = 8'h7F;
    step();
    din = '1; rst = 1'b1;
    step();
    chk("rst_mid_vld0", vld,  1'b0);
    chk("rst_mid_dout", dout, 3'b111);
    chk("rst_mid_Ys",   Ys,   1'b1);
    chk("rst_mid_Yex",  Yex,  1'b1);
    rst = 1'b0; rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_after_vld", vld, 1'b0);
    end

    // Two requests held continuously
    rst = 1'b1;
    step();
    rst = 1'b0; din = 8'b0111_1110;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_dout", dout, e37[k]);
      chk("hold_vld",  vld,  1'b1);
    end
    din = '1;
    for (int k = 0; k < 4; k++) step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      sel = ($urandom_range(0, 4) == 0);
      din = N'($urandom | $urandom | $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
